// File: rtl/common_pkg.sv
// Constants shared by the input-conditioning blocks.
// Reset values and polarity comparisons go through these.
package common_pkg;
  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;
  localparam logic NO   = 1'b0;
  localparam logic YES  = 1'b1;
endpackage

// File: rtl/clock_synchronizer.sv
// Multi-flop synchronizer chain for WIDTH independent asynchronous bits.
// Holds nothing but the flop chain, so placement and retiming attributes apply cleanly.
module clock_synchronizer
  import common_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_low,
  input  logic [WIDTH-1:0] bit_in,
  output logic [WIDTH-1:0] bit_out
);

  // Element 0 is the metastability-catching stage; element STAGES-1 is the output.
  (* ASYNC_REG = "TRUE", shreg_extract = "no", dont_retime = "true" *)
  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [STAGES-1:0][WIDTH-1:0] sync_d;

  assign sync_d = {sync_q[STAGES-2:0], bit_in};

  always_ff @(posedge clk or negedge reset_low) begin
    if (reset_low == LOW) begin
      sync_q <= {STAGES{{WIDTH{LOW}}}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign bit_out = sync_q[STAGES-1];

endmodule

// File: rtl/sync_edge_detector.sv
// Synchronizes an asynchronous level bus into clk and flags rising/falling/any edges.
// Edge outputs decode registers only, so they are glitch-free single-cycle pulses.
module sync_edge_detector
  import common_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_low,
  input  logic [WIDTH-1:0] bit_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] pos_edge,
  output logic [WIDTH-1:0] neg_edge,
  output logic [WIDTH-1:0] any_edge
);

  logic [WIDTH-1:0] level_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_d;

  clock_synchronizer #(
    .WIDTH (WIDTH),
    .STAGES(STAGES)
  ) u_sync (
    .clk      (clk),
    .reset_low(reset_low),
    .bit_in   (bit_in),
    .bit_out  (level_q)
  );

  assign prev_d = level_q;

  // prev clears with the chain, so an input held high through reset yields one pos_edge.
  always_ff @(posedge clk or negedge reset_low) begin
    if (reset_low == LOW) begin
      prev_q <= {WIDTH{LOW}};
    end else begin
      prev_q <= prev_d;
    end
  end

  assign level    = level_q;
  assign pos_edge = level_q & ~prev_q;
  assign neg_edge = ~level_q & prev_q;
  assign any_edge = level_q ^ prev_q;

endmodule

// File: tb/tb_sync_edge_detector.sv
// Random and directed stimulus on two instances (1b/2 stages, 4b/3 stages),
// checked against a history-of-samples model of the synchronizer behaviour.
module tb_sync_edge_detector;

  localparam int SA = 2;
  localparam int SB = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_a = 1'b0;
  logic [3:0] bit_b = 4'h0;

  logic       level_a, pos_a, neg_a, any_a;
  logic [3:0] level_b, pos_b, neg_b, any_b;

  int total = 0;
  int bad   = 0;

  // hist[i] = input captured i edges ago (0 while/after reset until new samples arrive)
  logic       hist_a[$];
  logic [3:0] hist_b[$];

  always #5 clk = ~clk;

  sync_edge_detector #(.WIDTH(1), .STAGES(SA)) dut_a (
    .clk(clk), .reset_low(rst_n), .bit_in(bit_a),
    .level(level_a), .pos_edge(pos_a), .neg_edge(neg_a), .any_edge(any_a)
  );

  sync_edge_detector #(.WIDTH(4), .STAGES(SB)) dut_b (
    .clk(clk), .reset_low(rst_n), .bit_in(bit_b),
    .level(level_b), .pos_edge(pos_b), .neg_edge(neg_b), .any_edge(any_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist_a.delete();
    hist_b.delete();
    for (int i = 0; i <= SA; i++) hist_a.push_back(1'b0);
    for (int i = 0; i <= SB; i++) hist_b.push_back(4'h0);
  endtask

  task automatic model_edge();
    logic       da;
    logic [3:0] db;
    if (!rst_n) begin
      model_reset();
    end else begin
      hist_a.push_front(bit_a);
      da = hist_a.pop_back();
      hist_b.push_front(bit_b);
      db = hist_b.pop_back();
    end
  endtask

  task automatic check_all();
    logic       la, pa;
    logic [3:0] lb, pb;
    la = hist_a[SA-1];
    pa = hist_a[SA];
    lb = hist_b[SB-1];
    pb = hist_b[SB];
    chk("a_level", 32'(level_a), 32'(la));
    chk("a_pos",   32'(pos_a),   32'(la & ~pa));
    chk("a_neg",   32'(neg_a),   32'(~la & pa));
    chk("a_any",   32'(any_a),   32'(la ^ pa));
    chk("b_level", 32'(level_b), 32'(lb));
    chk("b_pos",   32'(pos_b),   32'(lb & ~pb));
    chk("b_neg",   32'(neg_b),   32'(~lb & pb));
    chk("b_any",   32'(any_b),   32'(lb ^ pb));
    chk("a_pos_and_neg", 32'(pos_a & neg_a), 32'h0);
    chk("b_pos_and_neg", 32'(pos_b & neg_b), 32'h0);
  endtask

  task automatic cycle(input logic na, input logic [3:0] nb);
    bit_a = na;
    bit_b = nb;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  int any_cnt;

  initial begin
    model_reset();
    #1;
    check_all();

    // reset held while inputs toggle: everything stays 0
    for (int i = 0; i < 6; i++) begin
      cycle(1'($urandom), 4'($urandom));
      chk("rst_hold_level_b", 32'(level_b), 32'h0);
    end

    // release with inputs high: one pos_edge at edge STAGES-1 after release
    bit_a = 1'b1;
    bit_b = 4'hF;
    #3 rst_n = 1'b1;
    cycle(1'b1, 4'hF);
    chk("rel_b_e0", 32'(pos_b), 32'h0);
    cycle(1'b1, 4'hF);
    chk("rel_a_pos_e1", 32'(pos_a), 32'h1);
    chk("rel_b_e1", 32'(pos_b), 32'h0);
    cycle(1'b1, 4'hF);
    chk("rel_b_pos_e2", 32'(pos_b), 32'hF);
    cycle(1'b1, 4'hF);
    chk("rel_b_quiet", 32'(pos_b), 32'h0);

    // directed rise on a (STAGES=2): visible after second edge, one cycle only
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'h0);
    cycle(1'b1, 4'h0);
    chk("rise_e10_level", 32'(level_a), 32'h0);
    cycle(1'b1, 4'h0);
    chk("rise_e11_level", 32'(level_a), 32'h1);
    chk("rise_e11_pos", 32'(pos_a), 32'h1);
    cycle(1'b1, 4'h0);
    chk("rise_e12_pos", 32'(pos_a), 32'h0);
    chk("rise_e12_level", 32'(level_a), 32'h1);

    // directed fall
    cycle(1'b0, 4'h0);
    cycle(1'b0, 4'h0);
    chk("fall_neg", 32'(neg_a), 32'h1);
    chk("fall_any", 32'(any_a), 32'h1);
    chk("fall_pos", 32'(pos_a), 32'h0);
    cycle(1'b0, 4'h0);
    chk("fall_neg_once", 32'(neg_a), 32'h0);

    // toggle every cycle for 8 cycles
    any_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle((i < 8) ? ~(1'(i & 1)) : 1'b0, 4'h0);
      if (any_a) any_cnt++;
    end
    chk("toggle_any_count", 32'(any_cnt), 32'd8);

    // WIDTH=4 pattern
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'b0101);
    cycle(1'b0, 4'b0110);
    cycle(1'b0, 4'b0110);
    cycle(1'b0, 4'b0110);
    chk("w4_pos", 32'(pos_b), 32'b0010);
    chk("w4_neg", 32'(neg_b), 32'b0001);
    chk("w4_any", 32'(any_b), 32'b0011);

    // randomized run
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom));
    end

    // mid-run async reset with level high
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'hF);
    chk("pre_rst_level_a", 32'(level_a), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_level_a", 32'(level_a), 32'h0);
    chk("async_rst_level_b", 32'(level_b), 32'h0);
    model_reset();
    check_all();
    cycle(1'b1, 4'hF);
    cycle(1'b0, 4'h5);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
